rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the register file's single write port between two requesters: the pipeline writeback stage (`wb_*`, normally preferred) and an auxiliary writer (`aux_*`, e.g. multi-cycle multiply/divide or debug loader).
- Each side uses a valid/ready handshake.
- A starvation counter guarantees the auxiliary side a grant within a bounded number of cycles.
- The granted write is registered and driven onto the register file's `regwrite`/`writeaddr`/`writedata` inputs for exactly one cycle.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: consecutive denied aux cycles before aux is forced ahead of wb; legal range ≥1.
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: register data width.

Ports:
- `clk`  in  1  sole clock, rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `wb_valid`  in  1  writeback request.
- `wb_addr`  in  ADDR_W  writeback destination.
- `wb_data`  in  DATA_W  writeback value.
- `wb_ready`  out  1  writeback accepted this cycle when `wb_valid` is high.
- `aux_valid`  in  1  auxiliary request.
- `aux_addr`  in  ADDR_W  auxiliary destination.
- `aux_data`  in  DATA_W  auxiliary value.
- `aux_ready`  out  1  auxiliary accepted this cycle when `aux_valid` is high.
- `rf_regwrite`  out  1  register-file write enable, registered.
- `rf_writeaddr`  out  ADDR_W  register-file write address, registered.
- `rf_writedata`  out  DATA_W  register-file write data, registered.
- `force_aux`  out  1  high while aux holds forced priority.
- `wb_stall_cnt`  out  16  saturating count of cycles with `wb_valid && !wb_ready`.

## Operation
- A transfer occurs on a side when valid and ready are both high at a rising edge.
- Requesters hold valid/addr/data stable until their transfer; the arbiter never drops an accepted request.
- Starvation counter `starve` has width `$clog2(STARVE_LIMIT+1)`; it saturates at `STARVE_LIMIT`.
  - Increments each cycle with `aux_valid && !aux_ready`.
  - Clears on an aux transfer or on any cycle with `aux_valid` low.
- `force_aux = (starve == STARVE_LIMIT)`.
- Combinational ready, two modes:
  - NORMAL (`force_aux` = 0): `wb_ready = !reset`; `aux_ready = !reset && !wb_valid`.
  - FORCED (`force_aux` = 1): `aux_ready = !reset`; `wb_ready = 0`.
- Mode transitions:
  - NORMAL→FORCED when `starve` reaches `STARVE_LIMIT`.
  - FORCED→NORMAL after the aux transfer; `starve` clears the same edge.
  - If `aux_valid` drops while FORCED, return to NORMAL (`starve` = 0).
- On a transfer, the next edge loads `rf_writeaddr`/`rf_writedata` from the winner and sets `rf_regwrite` = 1, except when the address is 0: the request is consumed but `rf_regwrite` = 0.
- With no transfer, `rf_regwrite` = 0 next cycle; `rf_writeaddr`/`rf_writedata` hold their previous values.
- At most one transfer per cycle; both ready high only when `wb_valid` is low.
- Both valid with the same address: no merging, normal priority applies. The loser writes later, so last writer wins in grant order.
- `wb_stall_cnt` increments on each `wb_valid && !wb_ready` cycle and saturates at 16'hFFFF.

## Timing
- Reset (`reset` high at edge): `rf_regwrite` = 0, `rf_writeaddr` = 0, `rf_writedata` = 0, `starve` = 0, `force_aux` = 0, `wb_stall_cnt` = 0.
- While `reset` is high, `wb_ready` = `aux_ready` = 0.
- Reset mid-operation: a write registered in the preceding cycle is still presented that cycle. The edge sampling `reset` clears `rf_regwrite`, and no request is accepted during reset.
- Latency: transfer at edge N → `rf_regwrite` high for cycle N..N+1, and the register file commits on its following write phase.
- Throughput: one write per cycle. A continuous aux stream with wb idle is accepted every cycle.
- Worst-case aux wait under continuous wb traffic: `STARVE_LIMIT` denied cycles, then a grant on the next cycle.
- Worst-case wb wait: 1 cycle per forced aux grant.
- `force_aux` is registered-state derived, so its output is glitch-free.

## Test plan
- Reset values: after reset, all outputs 0. Assert `wb_valid`, addr 5, data 0xDEADBEEF, during reset → `wb_ready` = 0 and no write. Release reset → accept next edge; `rf_regwrite` = 1, `rf_writeaddr` = 5, `rf_writedata` = 0xDEADBEEF one cycle later.
- Priority: both valid, wb addr 3, aux addr 4, `STARVE_LIMIT` = 4 → wb granted; aux granted once `wb_valid` drops. Register-file writes occur in order 3 then 4.
- Starvation: `wb_valid` held high with a new address each cycle, `aux_valid` high with addr 9 → aux denied 4 cycles with `force_aux` = 1 in the 5th. Aux is accepted that cycle, `wb_ready` = 0 and `wb_stall_cnt` = 1. NORMAL resumes the next cycle.
- Address 0: aux writes addr 0, data 0x12345678 → `aux_ready` handshake completes and `rf_regwrite` stays 0.
- Reset mid-force: drive `starve` to 4, then assert `reset` one cycle → `force_aux` = 0, `starve` = 0, no write. Afterwards wb regains priority.
- Saturation: hold wb stalled with forced aux 70000 times (or `force` the counter to 0xFFFE) → `wb_stall_cnt` stops at 0xFFFF.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file's single write port between the
// writeback stage (preferred) and an auxiliary writer. A starvation counter
// forces the auxiliary side ahead after STARVE_LIMIT consecutive denials.
module rf_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,

    input  logic              aux_valid,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_data,
    output logic              aux_ready,

    output logic              rf_regwrite,
    output logic [ADDR_W-1:0] rf_writeaddr,
    output logic [DATA_W-1:0] rf_writedata,

    output logic              force_aux,
    output logic [15:0]       wb_stall_cnt
);

    localparam int unsigned STARVE_W  = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned STALL_W   = 16;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [STALL_W-1:0]  STALL_MAX  = {STALL_W{1'b1}};

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCED = 1'b1
    } mode_e;

    mode_e               state_q;
    mode_e               state_d;
    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    logic [STALL_W-1:0]  wb_stall_cnt_q;
    logic [STALL_W-1:0]  wb_stall_cnt_d;
    logic                rf_regwrite_q;
    logic                rf_regwrite_d;
    logic [ADDR_W-1:0]   rf_writeaddr_q;
    logic [ADDR_W-1:0]   rf_writeaddr_d;
    logic [DATA_W-1:0]   rf_writedata_q;
    logic [DATA_W-1:0]   rf_writedata_d;

    logic                wb_ready_c;
    logic                aux_ready_c;
    logic                wb_xfer_c;
    logic                aux_xfer_c;

    // Ready generation: wb preferred unless aux holds forced priority; nothing accepted in reset.
    always_comb begin
        wb_ready_c  = 1'b0;
        aux_ready_c = 1'b0;
        if (!reset) begin
            if (state_q == ST_FORCED) begin
                aux_ready_c = 1'b1;
            end else begin
                wb_ready_c  = 1'b1;
                aux_ready_c = !wb_valid;
            end
        end
        wb_xfer_c  = wb_valid && wb_ready_c;
        aux_xfer_c = aux_valid && aux_ready_c;
    end

    // Starvation counter: counts consecutive denied aux cycles, saturating at the limit.
    always_comb begin
        starve_d = starve_q;
        if (!aux_valid || aux_xfer_c) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // Mode next-state: enter FORCED when the counter saturates, leave once aux is served or gone.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NORMAL: begin
                if (starve_d == STARVE_MAX) begin
                    state_d = ST_FORCED;
                end
            end
            ST_FORCED: begin
                if (aux_xfer_c || !aux_valid) begin
                    state_d = ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    // Write port capture: load the winner's address/data; address 0 is consumed without a write.
    always_comb begin
        rf_regwrite_d  = 1'b0;
        rf_writeaddr_d = rf_writeaddr_q;
        rf_writedata_d = rf_writedata_q;
        if (wb_xfer_c) begin
            rf_regwrite_d  = (wb_addr != '0);
            rf_writeaddr_d = wb_addr;
            rf_writedata_d = wb_data;
        end else if (aux_xfer_c) begin
            rf_regwrite_d  = (aux_addr != '0);
            rf_writeaddr_d = aux_addr;
            rf_writedata_d = aux_data;
        end
    end

    // Saturating count of cycles where writeback is held off.
    always_comb begin
        wb_stall_cnt_d = wb_stall_cnt_q;
        if (wb_valid && !wb_ready_c && (wb_stall_cnt_q != STALL_MAX)) begin
            wb_stall_cnt_d = wb_stall_cnt_q + STALL_W'(1);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_NORMAL;
            starve_q       <= '0;
            wb_stall_cnt_q <= '0;
            rf_regwrite_q  <= 1'b0;
            rf_writeaddr_q <= '0;
            rf_writedata_q <= '0;
        end else begin
            state_q        <= state_d;
            starve_q       <= starve_d;
            wb_stall_cnt_q <= wb_stall_cnt_d;
            rf_regwrite_q  <= rf_regwrite_d;
            rf_writeaddr_q <= rf_writeaddr_d;
            rf_writedata_q <= rf_writedata_d;
        end
    end

    assign wb_ready     = wb_ready_c;
    assign aux_ready    = aux_ready_c;
    assign force_aux    = (state_q == ST_FORCED);
    assign rf_regwrite  = rf_regwrite_q;
    assign rf_writeaddr = rf_writeaddr_q;
    assign rf_writedata = rf_writedata_q;
    assign wb_stall_cnt = wb_stall_cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with hand-computed expectations.
module tb_rf_write_arbiter;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ready;
    logic              aux_valid;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_data;
    logic              aux_ready;
    logic              rf_regwrite;
    logic [ADDR_W-1:0] rf_writeaddr;
    logic [DATA_W-1:0] rf_writedata;
    logic              force_aux;
    logic [15:0]       wb_stall_cnt;

    int total;
    int bad;

    rf_write_arbiter #(
        .STARVE_LIMIT(4),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_ready    (wb_ready),
        .aux_valid   (aux_valid),
        .aux_addr    (aux_addr),
        .aux_data    (aux_data),
        .aux_ready   (aux_ready),
        .rf_regwrite (rf_regwrite),
        .rf_writeaddr(rf_writeaddr),
        .rf_writedata(rf_writedata),
        .force_aux   (force_aux),
        .wb_stall_cnt(wb_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        aux_valid = 1'b0;
        aux_addr  = '0;
        aux_data  = '0;
        step();
        step();

        // Reset state
        chk("rst_regwrite", 32'(rf_regwrite), 32'd0);
        chk("rst_addr", 32'(rf_writeaddr), 32'd0);
        chk("rst_data", rf_writedata, 32'd0);
        chk("rst_force", 32'(force_aux), 32'd0);
        chk("rst_stall", 32'(wb_stall_cnt), 32'd0);
        chk("rst_aux_ready", 32'(aux_ready), 32'd0);

        // Request during reset is not accepted
        wb_valid = 1'b1;
        wb_addr  = 5'd5;
        wb_data  = 32'hDEADBEEF;
        #1;
        chk("rst_wb_ready", 32'(wb_ready), 32'd0);
        step();
        chk("rst_no_write", 32'(rf_regwrite), 32'd0);
        chk("rst_no_stall", 32'(wb_stall_cnt), 32'd0);

        // Release reset: accepted on the next edge
        reset = 1'b0;
        #1;
        chk("rel_wb_ready", 32'(wb_ready), 32'd1);
        step();
        chk("rel_regwrite", 32'(rf_regwrite), 32'd1);
        chk("rel_addr", 32'(rf_writeaddr), 32'd5);
        chk("rel_data", rf_writedata, 32'hDEADBEEF);
        wb_valid = 1'b0;
        step();
        chk("idle_regwrite", 32'(rf_regwrite), 32'd0);
        chk("idle_hold_addr", 32'(rf_writeaddr), 32'd5);
        chk("idle_hold_data", rf_writedata, 32'hDEADBEEF);

        // Priority: wb first, then aux
        wb_valid  = 1'b1;
        wb_addr   = 5'd3;
        wb_data   = 32'h33;
        aux_valid = 1'b1;
        aux_addr  = 5'd4;
        aux_data  = 32'h44;
        #1;
        chk("pri_wb_ready", 32'(wb_ready), 32'd1);
        chk("pri_aux_ready", 32'(aux_ready), 32'd0);
        step();
        chk("pri_w1_we", 32'(rf_regwrite), 32'd1);
        chk("pri_w1_addr", 32'(rf_writeaddr), 32'd3);
        wb_valid = 1'b0;
        #1;
        chk("pri_aux_ready2", 32'(aux_ready), 32'd1);
        step();
        chk("pri_w2_we", 32'(rf_regwrite), 32'd1);
        chk("pri_w2_addr", 32'(rf_writeaddr), 32'd4);
        chk("pri_w2_data", rf_writedata, 32'h44);
        aux_valid = 1'b0;
        step();

        // Starvation: aux denied 4 cycles, forced in the 5th
        aux_valid = 1'b1;
        aux_addr  = 5'd9;
        aux_data  = 32'h99;
        wb_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb_addr = 5'(10 + i);
            wb_data = 32'(100 + i);
            #1;
            chk("stv_force_lo", 32'(force_aux), 32'd0);
            chk("stv_aux_deny", 32'(aux_ready), 32'd0);
            step();
            chk("stv_wb_addr", 32'(rf_writeaddr), 32'(10 + i));
        end
        wb_addr = 5'd14;
        wb_data = 32'd114;
        #1;
        chk("stv_force_hi", 32'(force_aux), 32'd1);
        chk("stv_aux_ready", 32'(aux_ready), 32'd1);
        chk("stv_wb_ready", 32'(wb_ready), 32'd0);
        step();
        chk("stv_aux_we", 32'(rf_regwrite), 32'd1);
        chk("stv_aux_addr", 32'(rf_writeaddr), 32'd9);
        chk("stv_aux_data", rf_writedata, 32'h99);
        chk("stv_stall", 32'(wb_stall_cnt), 32'd1);
        chk("stv_force_off", 32'(force_aux), 32'd0);
        aux_valid = 1'b0;
        #1;
        chk("stv_wb_back", 32'(wb_ready), 32'd1);
        step();
        chk("stv_wb_held_addr", 32'(rf_writeaddr), 32'd14);
        chk("stv_wb_held_data", rf_writedata, 32'd114);
        wb_valid = 1'b0;
        step();

        // Address 0: consumed without a write
        aux_valid = 1'b1;
        aux_addr  = 5'd0;
        aux_data  = 32'h12345678;
        #1;
        chk("a0_aux_ready", 32'(aux_ready), 32'd1);
        step();
        chk("a0_no_write", 32'(rf_regwrite), 32'd0);
        aux_valid = 1'b0;
        step();

        // Reset while aux holds forced priority
        wb_valid  = 1'b1;
        wb_addr   = 5'd7;
        wb_data   = 32'h77;
        aux_valid = 1'b1;
        aux_addr  = 5'd9;
        aux_data  = 32'h99;
        for (int i = 0; i < 4; i++) step();
        chk("rmf_force_hi", 32'(force_aux), 32'd1);
        reset = 1'b1;
        #1;
        chk("rmf_prev_write", 32'(rf_regwrite), 32'd1);
        chk("rmf_aux_ready", 32'(aux_ready), 32'd0);
        chk("rmf_wb_ready", 32'(wb_ready), 32'd0);
        step();
        chk("rmf_force_lo", 32'(force_aux), 32'd0);
        chk("rmf_no_write", 32'(rf_regwrite), 32'd0);
        reset = 1'b0;
        #1;
        chk("rmf_wb_prio", 32'(wb_ready), 32'd1);
        chk("rmf_aux_wait", 32'(aux_ready), 32'd0);
        step();
        chk("rmf_wb_addr", 32'(rf_writeaddr), 32'd7);
        wb_valid  = 1'b0;
        aux_valid = 1'b0;
        step();

        // Stall counter saturation
        force dut.wb_stall_cnt_q = 16'hFFFE;
        #1;
        release dut.wb_stall_cnt_q;
        chk("sat_preload", 32'(wb_stall_cnt), 32'hFFFE);
        wb_valid  = 1'b1;
        aux_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("sat_reach", 32'(wb_stall_cnt), 32'hFFFF);
        for (int i = 0; i < 5; i++) step();
        chk("sat_hold", 32'(wb_stall_cnt), 32'hFFFF);
        wb_valid  = 1'b0;
        aux_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
